// File: rtl/display_seq_ctrl.sv
// Sequencing controller for the seg7 digit: prescaler time-base, programmable
// period compare, 0..DIGIT_MAX digit register and run/stop/step/clear FSM.
module display_seq_ctrl #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [3:0]  DIGIT_MAX = 4'd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_step,
  input  logic        cmd_clear,
  input  logic        cmd_up,
  input  logic [7:0]  period_in,
  input  logic        period_load,
  output logic [3:0]  digit,
  output logic        tick,
  output logic        digit_wrap,
  output logic [1:0]  state,
  output logic [23:0] prescale
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_STEP  = 2'd3;

  // Command bit order in the sample/prev registers: {clear, stop, start, step}
  logic [3:0]  s_cmd;
  logic [3:0]  p_cmd;
  logic        e_clear;
  logic        e_stop;
  logic        e_start;
  logic        e_step;
  logic [23:0] compare;
  logic [23:0] compare_nxt;
  logic [3:0]  adv_digit;
  logic        adv_wrap;
  logic        terminal;

  assign e_clear  = s_cmd[3] & ~p_cmd[3];
  assign e_stop   = s_cmd[2] & ~p_cmd[2];
  assign e_start  = s_cmd[1] & ~p_cmd[1];
  assign e_step   = s_cmd[0] & ~p_cmd[0];
  assign terminal = (prescale >= compare);

  always_comb begin
    compare_nxt = (period_in == 8'd0) ? MAX_COUNT : {6'b0, period_in, 10'b0};
  end

  // Next digit for one advance; direction is taken straight from cmd_up
  always_comb begin
    adv_digit = digit;
    adv_wrap  = 1'b0;
    if (cmd_up) begin
      if (digit >= DIGIT_MAX) begin
        adv_digit = '0;
        adv_wrap  = 1'b1;
      end else begin
        adv_digit = digit + 4'd1;
      end
    end else if (digit == 4'd0) begin
      adv_digit = DIGIT_MAX;
      adv_wrap  = 1'b1;
    end else begin
      adv_digit = digit - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      digit      <= '0;
      prescale   <= '0;
      tick       <= 1'b0;
      digit_wrap <= 1'b0;
      compare    <= MAX_COUNT;
      s_cmd      <= '0;
      p_cmd      <= '1;
    end else begin
      s_cmd      <= {cmd_clear, cmd_stop, cmd_start, cmd_step};
      p_cmd      <= s_cmd;
      tick       <= 1'b0;
      digit_wrap <= 1'b0;
      if (period_load) begin
        compare <= compare_nxt;
      end
      if (e_clear) begin
        state    <= ST_IDLE;
        digit    <= '0;
        prescale <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            prescale <= '0;
            // A stop event outranks start/step even where it has no effect
            if (!e_stop) begin
              if (e_start) begin
                state <= ST_RUN;
              end else if (e_step) begin
                state <= ST_STEP;
              end
            end
          end
          ST_RUN: begin
            if (e_stop) begin
              state <= ST_PAUSE;
            end else if (terminal) begin
              prescale   <= '0;
              tick       <= 1'b1;
              digit      <= adv_digit;
              digit_wrap <= adv_wrap;
            end else begin
              prescale <= prescale + 24'd1;
            end
          end
          ST_PAUSE: begin
            if (!e_stop) begin
              if (e_start) begin
                state <= ST_RUN;
              end else if (e_step) begin
                state <= ST_STEP;
              end
            end
          end
          ST_STEP: begin
            digit      <= adv_digit;
            digit_wrap <= adv_wrap;
            state      <= ST_PAUSE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
